// File: rtl/instr_encoder_if.sv
// Request/response bus of the RV32I instruction encoder.
// The master issues field requests and drains encoded words; the slave is the encoder.
interface instr_encoder_if #(
    parameter int unsigned AW = 8
) ();
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    fmt;
    logic [6:0]    opcode;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [31:0]   imm;

    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic          out_err;

    modport master (
        output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err
    );

    modport slave (
        input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs fields into 32-bit words with immediate range
// checks, a per-sequence word address counter and a one-deep output register.
module instr_encoder #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    instr_encoder_if.slave bus,
    output logic [7:0]    err_cnt,
    output logic          busy,
    output logic          done
);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_ctr_q, addr_ctr_d;
    logic [CW-1:0] acc_cnt_q, acc_cnt_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_instr_q, out_instr_d;
    logic [AW-1:0] out_addr_q, out_addr_d;
    logic          out_err_q, out_err_d;

    logic          in_ready_c;
    logic          accept_c;
    logic [31:0]   enc_instr_c;
    logic          enc_err_c;
    logic          fits12_c, fits13_c, fits21_c;

    // Signed-range checks: all bits above the field's sign bit must match it.
    always_comb begin
        fits12_c = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
        fits13_c = (&bus.imm[31:12]) | ~(|bus.imm[31:12]);
        fits21_c = (&bus.imm[31:20]) | ~(|bus.imm[31:20]);
    end

    // Field packing; any failed check substitutes a NOP.
    always_comb begin
        enc_instr_c = '0;
        enc_err_c   = 1'b0;
        case (bus.fmt)
            3'd0: enc_instr_c = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            3'd1: begin
                enc_err_c   = ~fits12_c;
                enc_instr_c = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
            end
            3'd2: begin
                enc_err_c   = ~fits12_c;
                enc_instr_c = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3,
                               bus.imm[4:0], bus.opcode};
            end
            3'd3: begin
                enc_err_c   = ~fits13_c | bus.imm[0];
                enc_instr_c = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                               bus.imm[4:1], bus.imm[11], bus.opcode};
            end
            3'd4: begin
                enc_err_c   = |bus.imm[11:0];
                enc_instr_c = {bus.imm[31:12], bus.rd, bus.opcode};
            end
            3'd5: begin
                enc_err_c   = ~fits21_c | bus.imm[0];
                enc_instr_c = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                               bus.rd, bus.opcode};
            end
            default: enc_err_c = 1'b1;
        endcase
        if (enc_err_c) begin
            enc_instr_c = NOP;
        end
    end

    // Next-state: sequence FSM, address/accept/error counters and output register.
    always_comb begin
        state_d     = state_q;
        addr_ctr_d  = addr_ctr_q;
        acc_cnt_d   = acc_cnt_q;
        err_cnt_d   = err_cnt_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        out_err_d   = out_err_q;

        in_ready_c  = (state_q == ST_RUN) & (~out_valid_q | bus.out_ready);
        accept_c    = bus.in_valid & in_ready_c;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    addr_ctr_d = base_addr;
                    acc_cnt_d  = '0;
                    err_cnt_d  = '0;
                end
            end
            ST_RUN: begin
                if (accept_c) begin
                    addr_ctr_d = AW'(addr_ctr_q + AW'(1));
                    acc_cnt_d  = CW'(acc_cnt_q + CW'(1));
                    if (enc_err_c && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = 8'(err_cnt_q + 8'd1);
                    end
                    if (acc_cnt_q == CW'(DEPTH - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept_c) begin
            out_valid_d = 1'b1;
            out_instr_d = enc_instr_c;
            out_addr_d  = addr_ctr_q;
            out_err_d   = enc_err_c;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_ctr_q  <= '0;
            acc_cnt_q   <= '0;
            err_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_ctr_q  <= addr_ctr_d;
            acc_cnt_q   <= acc_cnt_d;
            err_cnt_q   <= err_cnt_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            out_err_q   <= out_err_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_err   = out_err_q;
    assign err_cnt       = err_cnt_q;
    assign busy          = (state_q == ST_RUN);
    assign done          = (state_q == ST_DONE);
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed vectors push expected words,
// a forked monitor pops and compares on every output handshake.
module tb_instr_encoder;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic [7:0] err_cnt;
    logic       busy;
    logic       done;

    instr_encoder_if #(.AW(8)) bus ();

    instr_encoder #(.DEPTH(16), .AW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .bus      (bus),
        .err_cnt  (err_cnt),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  addr;
        logic        err;
    } exp_t;

    int         n_cmp = 0;
    int         n_fail = 0;
    exp_t       sb[$];
    logic [7:0] exp_addr = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm,
                                input logic [31:0] exp, input logic err);
        vec_t v;
        v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.f7 = f7; v.imm = imm; v.exp = exp; v.err = err;
        return v;
    endfunction

    function automatic vec_t addi(input logic [4:0] r, input logic [31:0] exp);
        return mk(3'd1, 7'h13, r, 5'd0, 5'd0, 3'd0, 7'd0, {27'd0, r}, exp, 1'b0);
    endfunction

    task automatic drive(input vec_t v);
        bus.in_valid = 1'b1;
        bus.fmt = v.fmt; bus.opcode = v.op; bus.rd = v.rd; bus.rs1 = v.rs1;
        bus.rs2 = v.rs2; bus.funct3 = v.f3; bus.funct7 = v.f7; bus.imm = v.imm;
    endtask

    // Issue one request; expected word is queued at the cycle the handshake happens.
    task automatic send(input vec_t v);
        exp_t e;
        bit   ok = 1'b0;
        drive(v);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.instr = v.exp; e.addr = exp_addr; e.err = v.err;
                sb.push_back(e);
                exp_addr = 8'(exp_addr + 8'd1);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 want handshake within 50 cycles");
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic start_seq(input logic [7:0] b);
        start = 1'b1; base_addr = b;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = b;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0 && !bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_instr"}, bus.out_instr, 32'd0);
        check({tag, "_out_addr"}, 32'(bus.out_addr), 32'd0);
        check({tag, "_out_err"}, 32'(bus.out_err), 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_output: got 0x%08h want none", bus.out_instr);
                end else begin
                    e = sb.pop_front();
                    check("out_instr", bus.out_instr, e.instr);
                    check("out_addr", 32'(bus.out_addr), 32'(e.addr));
                    check("out_err", 32'(bus.out_err), 32'(e.err));
                end
            end
        end
    endtask

    initial begin
        vec_t  va, vb, v17;
        time   t0;

        rst = 1'b1; start = 1'b0; base_addr = 8'h00;
        bus.in_valid = 1'b0; bus.fmt = 3'd0; bus.opcode = 7'd0; bus.rd = 5'd0;
        bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.funct3 = 3'd0; bus.funct7 = 7'd0;
        bus.imm = 32'd0; bus.out_ready = 1'b1;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // T1/T2: basic formats, T3: error cases
        start_seq(8'h10);
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_after_start", 32'(done), 32'd0);
        send(mk(3'd1, 7'h03, 5'd5, 5'd6, 5'd0, 3'd2, 7'd0, 32'd100, 32'h06432283, 1'b0));
        send(mk(3'd2, 7'h23, 5'd0, 5'd7, 5'd5, 3'd2, 7'd0, 32'd100, 32'h0653A223, 1'b0));
        send(mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFF8, 32'hFE208CE3, 1'b0));
        send(mk(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000BEEF, 32'h002081B3, 1'b0));
        send(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h00000013, 1'b1));
        send(mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd5, 32'h00000013, 1'b1));
        send(mk(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h00000013, 1'b1));
        check("err_cnt_t3", 32'(err_cnt), 32'd3);
        send(mk(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123450B7, 1'b0));
        send(mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h001000EF, 1'b0));
        wait_drain();

        // T4: back-pressure holds the output register, then stream
        bus.out_ready = 1'b0;
        va = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 32'h80000093, 1'b0);
        send(va);
        vb = addi(5'd1, 32'h00100093);
        drive(vb);
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_out_instr", bus.out_instr, 32'h80000093);
            check("stall_out_addr", 32'(bus.out_addr), 32'h19);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        t0 = $time;
        send(vb);
        send(addi(5'd2, 32'h00200113));
        send(addi(5'd3, 32'h00300193));
        send(addi(5'd4, 32'h00400213));
        check("stream_cycles", 32'(($time - t0) / 10), 32'd4);

        // T5: DEPTH-th accept ends the sequence
        send(addi(5'd5, 32'h00500293));
        send(addi(5'd6, 32'h00600313));
        check("done_after_depth", 32'(done), 32'd1);
        check("busy_after_depth", 32'(busy), 32'd0);
        wait_drain();
        v17 = addi(5'd7, 32'h00700393);
        drive(v17);
        repeat (3) begin
            @(negedge clk);
            check("done_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk); #1;
        start_seq(8'hFF);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_err_cnt", 32'(err_cnt), 32'd0);
        send(v17);
        send(addi(5'd8, 32'h00800413));
        wait_drain();

        // T6: reset mid-run discards the pending word
        bus.out_ready = 1'b0;
        send(addi(5'd9, 32'h00900493));
        check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        check("pre_rst_out_addr", 32'(bus.out_addr), 32'h01);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        rst = 1'b0;
        sb.delete();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("idle_after_rst", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
